// File: rtl/arcade_input_pkg.sv
// Shared constants for the arcade input mapper: PS/2 scancodes, MiSTer joystick bit map
// and the active-low byte layout expected by the game core's INP ports.
package arcade_input_pkg;

    // Arrow keys match with or without the E0 extension, so only the low byte is compared.
    localparam logic [7:0] SC_P1_UP    = 8'h75;
    localparam logic [7:0] SC_P1_DOWN  = 8'h72;
    localparam logic [7:0] SC_P1_LEFT  = 8'h6B;
    localparam logic [7:0] SC_P1_RIGHT = 8'h74;
    localparam logic [8:0] SC_P1_TRIG1 = 9'h029;
    localparam logic [8:0] SC_P1_TRIG2 = 9'h014;

    localparam logic [8:0] SC_P2_UP    = 9'h02D;
    localparam logic [8:0] SC_P2_DOWN  = 9'h02B;
    localparam logic [8:0] SC_P2_LEFT  = 9'h023;
    localparam logic [8:0] SC_P2_RIGHT = 9'h034;
    localparam logic [8:0] SC_P2_TRIG1 = 9'h01C;
    localparam logic [8:0] SC_P2_TRIG2 = 9'h01B;

    localparam logic [8:0] SC_START1 = 9'h016;
    localparam logic [8:0] SC_F1     = 9'h005;
    localparam logic [8:0] SC_START2 = 9'h01E;
    localparam logic [8:0] SC_F2     = 9'h006;
    localparam logic [8:0] SC_COIN1  = 9'h02E;
    localparam logic [8:0] SC_COIN2  = 9'h036;

    localparam int JOY_WIDTH  = 16;
    localparam int JOY_RIGHT  = 0;
    localparam int JOY_LEFT   = 1;
    localparam int JOY_DOWN   = 2;
    localparam int JOY_UP     = 3;
    localparam int JOY_TRIG1  = 4;
    localparam int JOY_TRIG2  = 5;
    localparam int JOY_START  = 6;
    localparam int JOY_SELECT = 7;
    localparam int JOY_COIN   = 8;

    localparam int INP_TRIG1 = 1;
    localparam int INP_TRIG2 = 2;
    localparam int INP_DOWN  = 4;
    localparam int INP_UP    = 5;
    localparam int INP_RIGHT = 6;
    localparam int INP_LEFT  = 7;

    localparam int SYS_COIN   = 0;
    localparam int SYS_START1 = 4;

    typedef struct packed {
        logic left;
        logic right;
        logic up;
        logic down;
        logic trig2;
        logic trig1;
    } ctrl_t;

    function automatic ctrl_t joy_to_ctrl(input logic [5:0] joy);
        ctrl_t c;
        c.left  = joy[JOY_LEFT];
        c.right = joy[JOY_RIGHT];
        c.up    = joy[JOY_UP];
        c.down  = joy[JOY_DOWN];
        c.trig2 = joy[JOY_TRIG2];
        c.trig1 = joy[JOY_TRIG1];
        return c;
    endfunction

    // Unused byte positions stay 0 here and become constant 1 after inversion.
    function automatic logic [7:0] inp_byte_n(input ctrl_t c, input logic suppress_trig1);
        logic [7:0] b;
        b            = 8'h00;
        b[INP_LEFT]  = c.left;
        b[INP_RIGHT] = c.right;
        b[INP_UP]    = c.up;
        b[INP_DOWN]  = c.down;
        b[INP_TRIG2] = c.trig2;
        b[INP_TRIG1] = c.trig1 & ~suppress_trig1;
        return ~b;
    endfunction

endpackage

// File: rtl/pulse_stretch.sv
// Rising-edge triggered fixed-width pulse; edges arriving while a pulse is running are dropped.
module pulse_stretch #(
    parameter logic [23:0] WIDTH_CYCLES = 24'd480000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_in,
    output logic o_active
);

    logic        r_prev;
    logic [23:0] r_cnt;
    logic        w_rise;

    assign w_rise   = i_in & ~r_prev;
    assign o_active = (r_cnt != '0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prev <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_prev <= i_in;
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 24'd1;
            end else if (w_rise) begin
                r_cnt <= WIDTH_CYCLES;
            end
        end
    end

endmodule

// File: rtl/arcade_input_mapper.sv
// Merges PS/2 keyboard state and MiSTer joysticks into registered active-low INP bytes,
// with upright/cocktail merge, per-player autofire on trig1 and a stretched coin pulse.
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int          NUM_PLAYERS  = 2,
    parameter logic [23:0] COIN_PULSE   = 24'd480000,
    parameter logic [19:0] AUTOFIRE_DIV = 20'd400000
) (
    input  logic                        clk_sys,
    input  logic                        reset,
    input  logic [10:0]                 ps2_key,
    input  logic [16*NUM_PLAYERS-1:0]   joy_in,
    input  logic                        cabinet,
    input  logic [NUM_PLAYERS-1:0]      autofire_en,
    output logic [8*NUM_PLAYERS-1:0]    inp_n,
    output logic [7:0]                  sys_n
);

    logic       r_old_tog;
    ctrl_t      r_key_p1;
    ctrl_t      r_key_p2;
    logic       r_key_start1;
    logic       r_key_f1;
    logic       r_key_start2;
    logic       r_key_f2;
    logic       r_key_coin1;
    logic       r_key_coin2;

    logic [19:0] r_af_cnt;
    logic        r_af_phase;

    logic        w_key_event;
    logic        w_pressed;
    logic [8:0]  w_code;

    ctrl_t [NUM_PLAYERS-1:0]     w_raw;
    ctrl_t                       w_p2_raw;
    logic  [NUM_PLAYERS-1:0][7:0] w_inp_n;
    logic  [NUM_PLAYERS-1:0]     w_joy_coin;
    logic  [3:0]                 w_joy_start;
    logic  [3:0]                 w_start;
    logic                        w_coin_raw;
    logic                        w_coin_active;
    logic  [7:0]                 w_sys_n;

    assign w_key_event = ps2_key[10] ^ r_old_tog;
    assign w_pressed   = ps2_key[9];
    assign w_code      = ps2_key[8:0];

    // old_tog follows the toggle even in reset so releasing reset never fakes an event.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_old_tog    <= ps2_key[10];
            r_key_p1     <= '0;
            r_key_p2     <= '0;
            r_key_start1 <= 1'b0;
            r_key_f1     <= 1'b0;
            r_key_start2 <= 1'b0;
            r_key_f2     <= 1'b0;
            r_key_coin1  <= 1'b0;
            r_key_coin2  <= 1'b0;
        end else begin
            r_old_tog <= ps2_key[10];
            if (w_key_event) begin
                if (w_code[7:0] == SC_P1_UP)    r_key_p1.up    <= w_pressed;
                if (w_code[7:0] == SC_P1_DOWN)  r_key_p1.down  <= w_pressed;
                if (w_code[7:0] == SC_P1_LEFT)  r_key_p1.left  <= w_pressed;
                if (w_code[7:0] == SC_P1_RIGHT) r_key_p1.right <= w_pressed;
                if (w_code == SC_P1_TRIG1)      r_key_p1.trig1 <= w_pressed;
                if (w_code == SC_P1_TRIG2)      r_key_p1.trig2 <= w_pressed;
                if (w_code == SC_P2_UP)         r_key_p2.up    <= w_pressed;
                if (w_code == SC_P2_DOWN)       r_key_p2.down  <= w_pressed;
                if (w_code == SC_P2_LEFT)       r_key_p2.left  <= w_pressed;
                if (w_code == SC_P2_RIGHT)      r_key_p2.right <= w_pressed;
                if (w_code == SC_P2_TRIG1)      r_key_p2.trig1 <= w_pressed;
                if (w_code == SC_P2_TRIG2)      r_key_p2.trig2 <= w_pressed;
                if (w_code == SC_START1)        r_key_start1   <= w_pressed;
                if (w_code == SC_F1)            r_key_f1       <= w_pressed;
                if (w_code == SC_START2)        r_key_start2   <= w_pressed;
                if (w_code == SC_F2)            r_key_f2       <= w_pressed;
                if (w_code == SC_COIN1)         r_key_coin1    <= w_pressed;
                if (w_code == SC_COIN2)         r_key_coin2    <= w_pressed;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_af_cnt   <= '0;
            r_af_phase <= 1'b0;
        end else if (r_af_cnt == AUTOFIRE_DIV - 20'd1) begin
            r_af_cnt   <= '0;
            r_af_phase <= ~r_af_phase;
        end else begin
            r_af_cnt <= r_af_cnt + 20'd1;
        end
    end

    if (NUM_PLAYERS >= 2) begin : g_p2
        assign w_p2_raw = w_raw[1];
    end else begin : g_no_p2
        assign w_p2_raw = '0;
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        ctrl_t w_key;
        ctrl_t w_merged;
        logic  w_unused_joy;

        if (p == 0) begin : g_key_p1
            assign w_key = r_key_p1;
        end else if (p == 1) begin : g_key_p2
            assign w_key = r_key_p2;
        end else begin : g_key_none
            assign w_key = '0;
        end

        assign w_raw[p] = ctrl_t'(joy_to_ctrl(joy_in[JOY_WIDTH*p +: 6]) | w_key);

        // Upright cabinets share one control panel, so P2's controls also drive P1.
        if (p == 0) begin : g_merge
            assign w_merged = cabinet ? w_raw[0] : ctrl_t'(w_raw[0] | w_p2_raw);
        end else begin : g_own
            assign w_merged = w_raw[p];
        end

        assign w_inp_n[p]    = inp_byte_n(w_merged, autofire_en[p] & ~r_af_phase);
        assign w_joy_coin[p] = joy_in[JOY_WIDTH*p + JOY_COIN];
        assign w_unused_joy  = &{1'b0, joy_in[JOY_WIDTH*p + JOY_SELECT], joy_in[JOY_WIDTH*p + 9 +: 7]};
    end

    for (genvar k = 0; k < 4; k++) begin : g_start
        if (k < NUM_PLAYERS) begin : g_used
            assign w_joy_start[k] = joy_in[JOY_WIDTH*k + JOY_START];
        end else begin : g_absent
            assign w_joy_start[k] = 1'b0;
        end
    end

    assign w_start[0]   = w_joy_start[0] | r_key_start1 | r_key_f1;
    assign w_start[1]   = w_joy_start[1] | r_key_start2 | r_key_f2;
    assign w_start[3:2] = w_joy_start[3:2];

    assign w_coin_raw = (|w_joy_coin) | r_key_coin1 | r_key_coin2 | r_key_f1 | r_key_f2;

    pulse_stretch #(
        .WIDTH_CYCLES(COIN_PULSE)
    ) u_coin (
        .i_clk    (clk_sys),
        .i_reset  (reset),
        .i_in     (w_coin_raw),
        .o_active (w_coin_active)
    );

    always_comb begin
        w_sys_n           = 8'hFF;
        w_sys_n[SYS_COIN] = ~w_coin_active;
        for (int k = 0; k < 4; k++) begin
            w_sys_n[SYS_START1 + k] = ~w_start[k];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            inp_n <= '1;
            sys_n <= 8'hFF;
        end else begin
            inp_n <= w_inp_n;
            sys_n <= w_sys_n;
        end
    end

endmodule

// File: doc/arcade_input_mapper.md
Name: arcade_input_mapper

Overview:
- Parametrised successor to the fixed two-player keyboard/joystick merge logic in the SEGA System 1 top level.
- Decodes `ps2_key` events into held-key state and merges it with up to four MiSTer joysticks.
- Applies cabinet mode, per-player autofire and a fixed-width coin pulse.
- Produces registered active-low per-player and system input bytes that feed the game core's INP ports directly.

Parameters:
- NUM_PLAYERS, 2, number of player channels (1..4).
- COIN_PULSE, 24'd480000, coin output width in clk_sys cycles (10 ms at 48 MHz); must be ≥1.
- AUTOFIRE_DIV, 20'd400000, clk_sys cycles per autofire phase toggle; must be ≥1.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ps2_key  in  11  [10] event toggle, [9] pressed, [8:0] extended scancode.
- joy_in  in  16*NUM_PLAYERS  joystick p at [16p+15:16p]; bits [0]R [1]L [2]D [3]U [4]trig1 [5]trig2 [6]start [7]select [8]coin.
- cabinet  in  1  0 = upright (P2 controls ORed into P1), 1 = cocktail (separate).
- autofire_en  in  NUM_PLAYERS  per-player autofire enable on trig1.
- inp_n  out  8*NUM_PLAYERS  player p byte at [8p+7:8p], active-low {left,right,up,down,1,trig2,trig1,1}.
- sys_n  out  8  active-low {start4,start3,start2,start1,1,1,1,coin}.

Behaviour:
- **Reset:**
  - inp_n = all 1s; sys_n = 8'hFF.
  - All key latches, coin counter and autofire divider/phase cleared.
  - Reset dominates all other inputs in the same cycle.
- **Key event detection:**
  - Register ps2_key[10] as old_tog; an event occurs when ps2_key[10] != old_tog.
  - old_tog is loaded from ps2_key[10] during reset, so there is no spurious event after reset.
  - On an event, the matching latch is loaded with ps2_key[9]. Unmatched codes are ignored.
- **Keymap** (scancodes compared on [8:0]; arrows match any value of bit 8):
  - Player 1: up X75, down X72, left X6B, right X74, trig1 029, trig2 014.
  - Player 2: up 02D, down 02B, left 023, right 034, trig1 01C, trig2 01B.
  - Start1: 016 or F1 005. Start2: 01E or F2 006.
  - Coin: 02E, 036, F1, F2.
  - Players 3 and 4 have no keys.
- **Player merge:**
  - Each player's raw control = its key latch OR its joy_in bits.
  - When cabinet=0 and NUM_PLAYERS≥2, P1 also ORs in P2's raw controls; P2's own byte is unchanged.
  - start_k = joy_in start bit of any player k OR start key k.
  - With NUM_PLAYERS=1, the P2 merge is absent; start2 still comes from keys.
- **Autofire:**
  - Free-running divider counts 0..AUTOFIRE_DIV-1 and toggles phase at wrap.
  - When autofire_en[p]=1, trig1_out = raw_trig1 & phase; otherwise trig1_out = raw_trig1.
  - trig2 is never affected.
- **Coin:**
  - coin_raw = OR of all coin keys and all joy_in[8].
  - A rising edge of coin_raw while the counter is 0 loads COIN_PULSE.
  - The coin output is asserted while the counter ≠ 0; the counter decrements each cycle.
  - Edges while the counter ≠ 0 are ignored.
  - Holding coin_raw high does not extend or re-trigger the pulse; a new press requires release and re-press after the pulse ends.
- **Latency:**
  - All outputs are registered.
  - joy_in to output: 1 cycle.
  - ps2 event to output: 2 cycles (latch, then output register).
  - Coin rising edge to sys_n[0]=0: 2 cycles (edge register, counter).
- **Unused bits:** constant 1 in every byte; any unused sys_n start bits for players above NUM_PLAYERS are constant 1.
- **Simultaneous events:** a key release and a joystick press on the same control resolve to pressed (OR).

Decomposition:
- **Package arcade_input_pkg:**
  - Scancode localparams.
  - Joystick bit-index constants.
  - Byte-layout constants for inp_n/sys_n.
- **Sub-module pulse_stretch** (edge detect + down-counter, parameter WIDTH_CYCLES), instantiated for coin.
- The autofire divider is one shared instance in the top.

Test Plan:
1. Reset asserted with all joy_in=FFFF and keys pressed → inp_n=all 1s, sys_n=8'hFF; one cycle after release, inp_n reflects joy bits.
2. ps2_key toggle with {pressed=1, code 075} → inp_n[7:0]=8'hDF two cycles later; toggle again with pressed=0 → 8'hFF.
3. cabinet=0, joy_in P2 left → inp_n[7:0]=8'h7F and inp_n[15:8]=8'h7F; with cabinet=1, inp_n[7:0]=8'hFF.
4. COIN_PULSE=5, joy_in[8] held 20 cycles → sys_n[0]=0 for exactly 5 cycles; a second edge mid-pulse is ignored.
5. AUTOFIRE_DIV=4, autofire_en=01, P1 trig1 held → inp_n bit1 toggles every 4 cycles; P2 trig1 held is steady 0.
6. F1 press event → sys_n=8'hEE (start1 and coin) for the coin pulse duration; start1 stays low until the release event.
